nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder built around one 4-bit ripple adder slice.
//  - Accepts operand pairs over a valid/ready handshake.
//  - Feeds them to the slice one nibble per cycle, LSB nibble first, carrying between cycles.
//  - Collects the slice sums into a WIDTH-bit result, returned over a second valid/ready handshake.
//  - Trades latency for area: wide sums with a single four_bit_adder_df.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/four_bit_adder_df.sv | 22 ++
 rtl/nibble_serial_adder.sv | 102 ++++++++++
 tb/tb_nibble_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state codes.
// Pure declarations, no logic of its own.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/four_bit_adder_df.sv
// 4-bit dataflow ripple-carry adder slice; purely combinational, zero latency.
// No handshake: the enclosing block decides when its outputs are consumed.
module four_bit_adder_df (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);

   logic [4:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles; result valid NIBBLES edges after accept.
// Result is held in DONE until out_ready; operands are refused (in_ready=0) outside IDLE.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_t                 state, state_nx;
   logic [WIDTH-1:0]       opa, opb, result;
   logic                   carry, c_out_q;
   logic [CNT_W-1:0]       cnt;
   logic [NIBBLE_W-1:0]    slice_sum;
   logic                   slice_cout;
   logic [WIDTH+NIBBLE_W-1:0] result_cat;

   four_bit_adder_df u_slice (
      .x    (opa[NIBBLE_W-1:0]),
      .y    (opb[NIBBLE_W-1:0]),
      .c_in (carry),
      .s    (slice_sum),
      .c_out(slice_cout)
   );

   // Slice sum enters at the top so nibble 0 ends up at the bottom after NIBBLES shifts.
   assign result_cat = {slice_sum, result};

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid)         state_nx = ST_RUN;
         ST_RUN:  if (cnt == LAST_CNT)  state_nx = ST_DONE;
         ST_DONE: if (out_ready)        state_nx = ST_IDLE;
         default:                       state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa     <= '0;
         opb     <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         c_out_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= c_in;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               opa    <= opa >> NIBBLE_W;
               opb    <= opb >> NIBBLE_W;
               carry  <= slice_cout;
               result <= result_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) c_out_q <= slice_cout;
            end
            default: ;
         endcase
      end
   end

   assign sum   = result;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed corner cases plus random
// back-to-back operations with random output stalls, checked against plain a+b+c_in.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        c_out;

   int checks = 0;
   int errors = 0;

   localparam int EXP_LAT = 4;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .c_out    (c_out)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
      int unsigned t;
      t = int'(x) + int'(y) + int'(ci);
      return t[16:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation from IDLE; returns result, edges from accept to out_valid (-1 on timeout).
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input int stall,
                        output logic [15:0] os, output logic oc, output int lat);
      a = ia; b = ib; c_in = ic; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      if (!out_valid) lat = -1;
      os = sum;
      oc = c_out;
      repeat (stall) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
      repeat (2) step();
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (sum !== 16'h0000)   begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      checks++; if (c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out got %b want 0", c_out); end
      rst = 1'b0;
      out_ready = 1'b0;
      step();
   endtask

   task automatic test_directed();
      logic [15:0] va[5], vb[5];
      logic        vc[5];
      logic [15:0] s;
      logic        co;
      logic [16:0] exp;
      int          lat;
      va = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h8000, 16'hABCD};
      vb = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h1111};
      vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vc[i], 0, s, co, lat);
         exp = ref_add(va[i], vb[i], vc[i]);
         checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, EXP_LAT); end
         checks++; if (s !== exp[15:0]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, s, exp[15:0]); end
         checks++; if (co !== exp[16]) begin errors++; $display("FAIL dir%0d_c_out got %b want %b", i, co, exp[16]); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      a = 16'h1234; b = 16'h4321; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      step();
      a = 16'hAAAA; b = 16'h1111;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, EXP_LAT); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got %b want 1", i, out_valid); end
         checks++; if (sum !== 16'h5555)   begin errors++; $display("FAIL bp_hold_sum%0d got %h want 5555", i, sum); end
         checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_hold_in_ready%0d got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
      step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_next got in_ready=%b want 0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL bp_next_latency got %0d want %0d", lat, EXP_LAT); end
      checks++; if (sum !== 16'hBBBB || c_out !== 1'b0)
         begin errors++; $display("FAIL bp_next_result got %b_%h want 0_bbbb", c_out, sum); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] s;
      logic        co;
      int          lat;
      bit          seen;
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL midrun_reset got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
      checks++; if (sum !== 16'h0000 || c_out !== 1'b0)
         begin errors++; $display("FAIL midrun_reset_result got %b_%h want 0_0000", c_out, sum); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL midrun_no_output got out_valid=1 want 0"); end
      do_op(16'hABCD, 16'h1111, 1'b0, 1, s, co, lat);
      checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL midrun_next_latency got %0d want %0d", lat, EXP_LAT); end
      checks++; if (s !== 16'hBCDE || co !== 1'b0)
         begin errors++; $display("FAIL midrun_next_result got %b_%h want 0_bcde", co, s); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ra, rb, s;
      logic        rc, co;
      logic [16:0] exp;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         if (i % 10 == 0) begin ra = 16'hFFFF; rb = 16'hFFFF - 16'(i); end
         do_op(ra, rb, rc, int'($urandom_range(0, 3)), s, co, lat);
         exp = ref_add(ra, rb, rc);
         checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, EXP_LAT); end
         checks++; if ({co, s} !== exp)
            begin errors++; $display("FAIL rnd%0d_result a=%h b=%h ci=%b got %h want %h", i, ra, rb, rc, {co, s}, exp); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
